exc_vector_loader: RTL
======================

// Module: exc_vector_loader
// PURPOSE
//  Exception-entry sequencer for the multicycle MIPS datapath; reads from the memory address path that the IorD mux drives.
//  On an exception it drives the IorD select to the vector byte address (253/254/255), waits out memory latency,
//  captures the handler byte from memory, and produces EPC and new-PC load strobes.
//  Sits beside the main control FSM: control raises exc_req, this block owns IorD/PC/EPC until done.
// PARAMETERS
//  MEM_LAT   1   wait cycles between address presentation and valid mem_data_in (legal 1..7)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  exc_req      in   1   exception request, sampled only in IDLE
//  exc_code     in   2   01=invalid opcode, 10=overflow, 11=div-by-zero, 00=none
//  pc_in        in   32  current PC (already PC+4 of faulting instr)
//  mem_data_in  in   32  memory read data; handler address in bits [7:0]
//  iord_sel     out  3   IorD mux select: 000 idle, 010/011/100 for codes 01/10/11
//  epc_wr       out  1   one-cycle EPC write strobe
//  epc_data     out  32  value to write into EPC
//  pc_wr        out  1   one-cycle PC write strobe
//  pc_data      out  32  new PC = zero-extended handler byte
//  busy         out  1   high from acceptance until return to IDLE
//  done         out  1   one-cycle completion pulse
//  cause        out  32  exception cause register (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; iord_sel=000; epc_wr=pc_wr=done=busy=0; epc_data=pc_data=cause=0; wait counter=0.
//  Reset mid-sequence aborts immediately; no strobe issued in the reset cycle or after.
//  States: IDLE -> ADDR -> WAIT -> LOAD -> DONE -> IDLE.
//   IDLE: exc_req=1 and exc_code!=00 -> latch code, epc_data<=pc_in-32'd4, go ADDR. exc_code=00 ignored.
//   ADDR: iord_sel=vector select, epc_wr=1 (exactly one cycle), busy=1, counter<=MEM_LAT-1, go WAIT.
//   WAIT: iord_sel held; counter decrements; at 0 go LOAD. MEM_LAT=1 -> exactly one WAIT cycle.
//   LOAD: pc_data<={24'b0,mem_data_in[7:0]}, pc_wr=1 one cycle, iord_sel still held.
//   DONE: done=1, iord_sel=000, busy=0 next cycle; returns IDLE.
//  Latency: exc_req accepted at edge N -> epc_wr at N+1 -> pc_wr at N+2+MEM_LAT -> done at N+3+MEM_LAT.
//  exc_req/exc_code changes while busy are ignored; no queueing. New request accepted first cycle back in IDLE.
//  epc_data subtraction is modulo 2^32 (pc_in=0 -> 32'hFFFFFFFC). mem_data_in[31:8] ignored.
//  pc_data/epc_data hold last value between sequences; only strobes qualify them.
// CONFIGURATION
//  EXC_CAUSE_REG_EN defined: cause loaded with {30'b0,exc_code} in ADDR cycle, held until next exception or reset.
//  EXC_CAUSE_REG_EN undefined: no cause register; cause tied to 32'b0. All other behaviour identical.
// TESTING
//  reset; exc_req=1,code=01,pc_in=0x104,mem[253]=0x40 -> iord_sel=010, epc_wr w/ epc_data=0x100, pc_wr w/ pc_data=0x40, done at N+4.
//  code=10, mem[254]=0xFFFFFF80 -> iord_sel=011, pc_data=0x80 (upper bits discarded).
//  code=11, pc_in=0 -> iord_sel=100, epc_data=0xFFFFFFFC; cause=3 with EXC_CAUSE_REG_EN, 0 without.
//  exc_req=1,code=00 -> stays IDLE, no strobes, iord_sel=000; second exc_req during WAIT ignored.
//  reset asserted in WAIT -> next cycle all outputs at reset values, pc_wr never pulses.
//  MEM_LAT=3 -> pc_wr exactly 5 cycles after acceptance edge; back-to-back requests each produce one done.

Source files
------------

// File: rtl/exc_vector_loader_if.sv
// Exception-loader bus: request side from control, memory read data in, IorD/EPC/PC/status out.
interface exc_vector_loader_if;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic [2:0]  iord_sel;
    logic        epc_wr;
    logic [31:0] epc_data;
    logic        pc_wr;
    logic [31:0] pc_data;
    logic        busy;
    logic        done;
    logic [31:0] cause;

    modport master (
        output exc_req, exc_code, pc_in, mem_data_in,
        input  iord_sel, epc_wr, epc_data, pc_wr, pc_data, busy, done, cause
    );

    modport slave (
        input  exc_req, exc_code, pc_in, mem_data_in,
        output iord_sel, epc_wr, epc_data, pc_wr, pc_data, busy, done, cause
    );
endinterface

// File: rtl/exc_vector_loader.sv
// Exception-entry sequencer: selects the vector byte address, waits out memory latency, loads EPC/PC.
// Optional cause register enabled by defining EXC_CAUSE_REG_EN.
module exc_vector_loader #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    exc_vector_loader_if.slave   bus
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [CODE_W-1:0]   code_q,     code_d;
    logic [SEL_W-1:0]    iord_sel_q, iord_sel_d;
    logic                epc_wr_q,   epc_wr_d;
    logic [DATA_W-1:0]   epc_data_q, epc_data_d;
    logic                pc_wr_q,    pc_wr_d;
    logic [DATA_W-1:0]   pc_data_q,  pc_data_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    // Only the handler byte of the memory word matters.
    logic unused_mem_hi;
    assign unused_mem_hi = ^bus.mem_data_in[31:8];

    // Vector byte addresses 253/254/255 sit behind IorD selects 2/3/4.
    function automatic logic [SEL_W-1:0] vec_sel(input logic [CODE_W-1:0] code);
        logic [SEL_W-1:0] sel;
        sel = '0;
        case (code)
            2'b01:   sel = 3'b010;
            2'b10:   sel = 3'b011;
            2'b11:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            iord_sel_q <= '0;
            epc_wr_q   <= 1'b0;
            epc_data_q <= '0;
            pc_wr_q    <= 1'b0;
            pc_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            iord_sel_q <= iord_sel_d;
            epc_wr_q   <= epc_wr_d;
            epc_data_q <= epc_data_d;
            pc_wr_q    <= pc_wr_d;
            pc_data_q  <= pc_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        iord_sel_d = iord_sel_q;
        epc_wr_d   = 1'b0;
        epc_data_d = epc_data_q;
        pc_wr_d    = 1'b0;
        pc_data_d  = pc_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.exc_req && (bus.exc_code != 2'b00)) begin
                    code_d     = bus.exc_code;
                    epc_data_d = bus.pc_in - 32'd4;
                    busy_d     = 1'b1;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                iord_sel_d = vec_sel(code_q);
                epc_wr_d   = 1'b1;
                cnt_d      = CNT_W'(MEM_LAT - 1);
                state_d    = S_WAIT;
            end
            // Counter starts at MEM_LAT-1 so WAIT lasts exactly MEM_LAT cycles.
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOAD: begin
                pc_data_d = {24'b0, bus.mem_data_in[7:0]};
                pc_wr_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_d     = 1'b1;
                iord_sel_d = '0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef EXC_CAUSE_REG_EN
    logic [DATA_W-1:0] cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= '0;
        end else begin
            cause_q <= cause_d;
        end
    end

    always_comb begin
        cause_d = cause_q;
        if (state_q == S_ADDR) begin
            cause_d = {30'b0, code_q};
        end
    end

    assign bus.cause = cause_q;
`else
    assign bus.cause = '0;
`endif

    assign bus.iord_sel = iord_sel_q;
    assign bus.epc_wr   = epc_wr_q;
    assign bus.epc_data = epc_data_q;
    assign bus.pc_wr    = pc_wr_q;
    assign bus.pc_data  = pc_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
